whiten_sequencer: RTL
=====================

// Module: whiten_sequencer
// PURPOSE
//  Frame controller for the whitening datapath (centre -> covariance -> eigen-decomposition -> projection).
//  - Collects SIZE_B multichannel samples into a SIZE_A x SIZE_B frame.
//  - Presents the frame to the datapath and holds the datapath in reset while filling.
//  - Releases reset and waits SETTLE_CYCLES for the iterative eigen solver to converge.
//  - Captures the projected result and streams it out one column (sample) per beat.
// PARAMETERS
//  SIZE_A         8    channels per sample (frame rows)
//  SIZE_B         8    samples per frame (frame columns), >=2
//  SETTLE_CYCLES  64   cycles the datapath runs out of reset before the result is captured, >=1
// PORTS
//  clk        in   1                 system clock, all state on posedge
//  rst        in   1                 asynchronous active-low reset
//  flush      in   1                 sync abort: drop the current frame, return to FILL
//  in_valid   in   1                 input sample valid
//  in_ready   out  1                 input sample accepted when in_valid & in_ready
//  in_data    in   integer[SIZE_A]   one sample, all channels (signed 32-bit)
//  dp_mat     out  integer[SIZE_A][SIZE_B]  frame driven to the datapath's mat input (registered)
//  dp_rst     out  1                 datapath reset, active-low (0 = hold datapath in reset)
//  dp_result  in   integer[SIZE_A][SIZE_B]  datapath mat_out
//  out_valid  out  1                 output column valid
//  out_ready  in   1                 downstream accepts when out_valid & out_ready
//  out_data   out  integer[SIZE_A]   column rd_col of the captured result
//  busy       out  1                 1 in RUN or DRAIN
//  frame_cnt  out  16                frames fully drained, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=FILL; wr_col=rd_col=0; dp_mat, result buffer and frame_cnt = 0.
//   - dp_rst=0, in_ready=0, out_valid=0, busy=0.
//   - in_ready rises on the first clock edge after reset release.
//  FILL:
//   - in_ready=1, dp_rst=0.
//   - Each accepted beat writes dp_mat[ch][wr_col] <= in_data[ch] for all ch; wr_col++.
//   - On accepting the beat with wr_col==SIZE_B-1: go to RUN, settle_cnt=0, wr_col=0.
//  RUN:
//   - in_ready=0, dp_rst=1, busy=1; dp_mat is held constant.
//   - settle_cnt increments each cycle.
//   - In the cycle with settle_cnt==SETTLE_CYCLES-1: result buffer <= dp_result, go to DRAIN, rd_col=0.
//   - dp_rst returns to 0 the cycle DRAIN is entered.
//  DRAIN:
//   - out_valid=1, out_data[ch]=buffer[ch][rd_col], busy=1.
//   - out_data is stable while out_valid & !out_ready.
//   - On a handshake, rd_col++.
//   - On the handshake with rd_col==SIZE_B-1: frame_cnt++, go to FILL.
//   - The FILL-state in_ready=1 is visible the next cycle; no input overlap with DRAIN.
//  Timing:
//   - Last input accepted at edge T.
//   - dp_rst=1 for edges T+1 .. T+SETTLE_CYCLES.
//   - Capture at edge T+SETTLE_CYCLES.
//   - out_valid=1 after that edge.
//   - Frame throughput = SIZE_B + SETTLE_CYCLES + SIZE_B cycles minimum.
//  flush (highest priority, any state):
//   - Next state FILL; wr_col=rd_col=settle_cnt=0; dp_rst=0; out_valid=0.
//   - frame_cnt is unchanged. dp_mat contents may remain (overwritten by the next fill).
//   - A beat presented with flush=1 is not written, even if in_valid & in_ready.
//   - A handshake coincident with flush in DRAIN does not count a frame.
//  Data:
//   - Values pass through unmodified; no arithmetic in this block.
//   - The counters are the only arithmetic: wr_col/rd_col clog2(SIZE_B) bits, settle_cnt clog2(SETTLE_CYCLES+1) bits.
//  Asynchronous reset mid-frame discards everything; there is no partial output.
// TESTING  (SIZE_A=2, SIZE_B=4, SETTLE_CYCLES=5, dp_result driven by a model)
//  1. Back-to-back frame: feed 4 beats {c,10+c} for c=0..3 with in_valid=1.
//     -> dp_mat={{0,1,2,3},{10,11,12,13}}; dp_rst=1 for exactly 5 cycles; out_valid 1 cycle after capture.
//  2. Model result {{1,2,3,4},{5,6,7,8}}, out_ready=1.
//     -> out_data {1,5},{2,6},{3,7},{4,8} on consecutive cycles; frame_cnt 0->1; in_ready=1 the next cycle.
//  3. Input bubbles (in_valid 1,0,1,0...) and out_ready stalls of 3 cycles.
//     -> no lost or duplicated columns; out_data stable during stalls.
//  4. flush in FILL after 2 beats, then 4 new beats {7,8}.
//     -> all columns come from the new beats; RUN entered only after 4 post-flush beats.
//  5. flush during DRAIN on the handshake of column 2.
//     -> out_valid=0 next cycle, frame_cnt unchanged, FILL at wr_col=0.
//  6. Async rst pulse during RUN (settle_cnt=3).
//     -> dp_rst=0, busy=0 immediately; after release, a full new frame is required. Also preload frame_cnt=0xFFFF and complete a frame -> 0.

Source files
------------

// File: rtl/whiten_sequencer.sv
// rtl/whiten_sequencer.sv - frame fill / settle / drain controller for the whitening datapath
// Collects a frame, runs the datapath out of reset for a fixed settle time, then streams the result.
module whiten_sequencer #(
  parameter int SIZE_A        = 8,
  parameter int SIZE_B        = 8,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_data   [SIZE_A],
  output logic signed [31:0] dp_mat    [SIZE_A][SIZE_B],
  output logic               dp_rst,
  input  logic signed [31:0] dp_result [SIZE_A][SIZE_B],
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_data  [SIZE_A],
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam int CW = $clog2(SIZE_B);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COL    = CW'(SIZE_B - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state, state_nxt;
  logic                armed;
  logic [CW-1:0]       wr_col, rd_col;
  logic [SW-1:0]       settle_cnt;
  logic signed [31:0]  res_buf [SIZE_A][SIZE_B];

  logic in_acc, out_hs, last_in, settle_done, last_out;

  // A beat or handshake coincident with flush is discarded.
  assign in_acc      = in_valid & in_ready & ~flush;
  assign out_hs      = out_valid & out_ready & ~flush;
  assign last_in     = in_acc && (wr_col == LAST_COL);
  assign settle_done = (state == RUN) && (settle_cnt == LAST_SETTLE);
  assign last_out    = out_hs && (rd_col == LAST_COL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (last_in)     state_nxt = RUN;
        RUN:     if (settle_done) state_nxt = DRAIN;
        DRAIN:   if (last_out)    state_nxt = FILL;
        default:                  state_nxt = FILL;
      endcase
    end
  end

  // armed keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready  = (state == FILL) && armed;
    dp_rst    = (state == RUN);
    out_valid = (state == DRAIN);
    busy      = (state == RUN) || (state == DRAIN);
  end

  always_comb begin
    for (int ch = 0; ch < SIZE_A; ch++) out_data[ch] = res_buf[ch][rd_col];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed      <= 1'b0;
      wr_col     <= '0;
      rd_col     <= '0;
      settle_cnt <= '0;
      frame_cnt  <= '0;
      for (int ch = 0; ch < SIZE_A; ch++) begin
        for (int c = 0; c < SIZE_B; c++) begin
          dp_mat[ch][c]  <= '0;
          res_buf[ch][c] <= '0;
        end
      end
    end else begin
      armed <= 1'b1;
      if (flush) begin
        wr_col     <= '0;
        rd_col     <= '0;
        settle_cnt <= '0;
      end else begin
        case (state)
          FILL: begin
            if (in_acc) begin
              for (int ch = 0; ch < SIZE_A; ch++) dp_mat[ch][wr_col] <= in_data[ch];
              wr_col     <= last_in ? '0 : wr_col + CW'(1);
              settle_cnt <= '0;
            end
          end
          RUN: begin
            settle_cnt <= settle_cnt + SW'(1);
            if (settle_done) begin
              for (int ch = 0; ch < SIZE_A; ch++) begin
                for (int c = 0; c < SIZE_B; c++) res_buf[ch][c] <= dp_result[ch][c];
              end
              rd_col <= '0;
            end
          end
          DRAIN: begin
            if (out_hs) begin
              rd_col <= last_out ? '0 : rd_col + CW'(1);
              if (last_out) frame_cnt <= frame_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
